uart_mult_byte_tx: RTL

UART_MULT_BYTE_TX -- requirements
Module: uart_mult_byte_tx

---
 rtl/uart_pkt_pkg.sv | 24 ++
 rtl/uart_byte_tx.sv | 70 +++++++
 rtl/uart_mult_byte_tx.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkt_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkt_pkg
// Constants and types shared by the multi-byte UART packet transmitter and
// its matching receiver: frame header/tail bytes, payload byte count, and the
// control FSM state encoding.
// -----------------------------------------------------------------------------
package uart_pkt_pkg;

  localparam logic [7:0] HDR0 = 8'hAA;
  localparam logic [7:0] HDR1 = 8'h55;
  localparam logic [7:0] TAIL = 8'h0D;

  // dataA, dataB hi/lo, dataC hi/lo, dataD
  localparam int PAYLOAD_BYTES = 6;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SEND = 3'd2,
    ST_NEXT = 3'd3,
    ST_DONE = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_byte_tx.sv
// -----------------------------------------------------------------------------
// uart_byte_tx
// Single-byte 8N1 serializer: start bit 0, eight data bits LSB first, stop
// bit 1, each bit held BAUD_CNT clock cycles.
//
// Ports:
//   sys_clk    clock, rising edge
//   sys_rst_n  asynchronous active-low reset (line forced idle high)
//   start      begin a byte; honoured only while busy is low
//   data[7:0]  byte to send, captured on start
//   busy       high while a byte is on the line
//   done       high during the last cycle of the stop bit
//   txd        serial line, idle high
// -----------------------------------------------------------------------------
module uart_byte_tx #(
  parameter int BAUD_CNT = 434
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       txd
);

  localparam int CW = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;

  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_idx;   // 0 = start, 1..8 = data, 9 = stop
  logic [8:0]    shift;     // remaining data bits, refilled with 1s
  logic          bit_end;

  assign bit_end = busy && (baud_cnt == CW'(BAUD_CNT - 1));
  // Combinational so the controller can launch the next byte with minimal idle.
  assign done    = bit_end && (bit_idx == 4'd9);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= 4'd0;
      shift    <= '1;
      txd      <= 1'b1;
    end else if (!busy) begin
      if (start) begin
        busy     <= 1'b1;
        baud_cnt <= '0;
        bit_idx  <= 4'd0;
        shift    <= {1'b1, data};
        txd      <= 1'b0;
      end
    end else if (bit_end) begin
      baud_cnt <= '0;
      if (bit_idx == 4'd9) begin
        busy <= 1'b0;
        txd  <= 1'b1;
      end else begin
        bit_idx <= bit_idx + 4'd1;
        txd     <= shift[0];
        shift   <= {1'b1, shift[8:1]};
      end
    end else begin
      baud_cnt <= baud_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_mult_byte_tx.sv
// -----------------------------------------------------------------------------
// uart_mult_byte_tx
// Sends one framed packet per accepted request:
//   AA 55 pack_num dataA dataB[15:8] dataB[7:0] dataC[15:8] dataC[7:0] dataD
//   [checksum] 0D
// The checksum byte (8-bit sum of pack_num..dataD) is present only when the
// macro UART_TX_CHECKSUM_EN is defined; otherwise the frame is 10 bytes.
//
// Ports:
//   sys_clk     clock, rising edge
//   sys_rst_n   asynchronous active-low reset; aborts any frame in progress
//   send_req    single-cycle request, ignored while busy or in DONE
//   dataA..D    payload fields, latched on accept
//   send_busy   high from the cycle after accept until the done pulse
//   send_done   one-cycle pulse at frame completion (busy low in that cycle)
//   pack_num    frame sequence number, increments at each send_done
//   uart_txd    serial line, idle high
// -----------------------------------------------------------------------------
module uart_mult_byte_tx
  import uart_pkt_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int UART_BPS = 115200
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        send_req,
  input  logic [7:0]  dataA,
  input  logic [15:0] dataB,
  input  logic [15:0] dataC,
  input  logic [7:0]  dataD,
  output logic        send_busy,
  output logic        send_done,
  output logic [7:0]  pack_num,
  output logic        uart_txd
);

  localparam int BAUD_CNT = CLK_FREQ / UART_BPS;
`ifdef UART_TX_CHECKSUM_EN
  localparam int FRAME_LEN = PAYLOAD_BYTES + 5;
`else
  localparam int FRAME_LEN = PAYLOAD_BYTES + 4;
`endif

  tx_state_t   state, next_state;
  logic [3:0]  byte_idx;
  logic [3:0]  sel_idx;
  logic        last_byte;
  logic        byte_start, byte_busy, byte_done;
  logic [7:0]  tx_byte;
  logic [7:0]  a_q, d_q;
  logic [15:0] b_q, c_q;

  assign last_byte = (byte_idx == 4'(FRAME_LEN - 1));

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ST_IDLE;
    else            state <= next_state;
  end

  // Next-state logic
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: if (send_req) next_state = ST_LOAD;
      ST_LOAD: next_state = ST_SEND;
      ST_SEND: if (byte_done) next_state = ST_NEXT;
      ST_NEXT: next_state = last_byte ? ST_DONE : ST_SEND;
      ST_DONE: next_state = ST_IDLE;   // a request here is dropped
      default: next_state = ST_IDLE;
    endcase
  end

  // Outputs. In NEXT the following byte is launched straight away, so the
  // line idles for a single cycle between stop and start bits.
  always_comb begin
    byte_start = 1'b0;
    sel_idx    = byte_idx;
    send_busy  = 1'b0;
    send_done  = 1'b0;
    unique case (state)
      ST_LOAD: begin
        send_busy  = 1'b1;
        byte_start = !byte_busy;
      end
      ST_SEND: send_busy = 1'b1;
      ST_NEXT: begin
        send_busy  = 1'b1;
        sel_idx    = byte_idx + 4'd1;
        byte_start = !last_byte && !byte_busy;
      end
      ST_DONE: send_done = 1'b1;
      default: ;
    endcase
  end

  // Payload latch, byte index and sequence number
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      a_q      <= 8'h00;
      b_q      <= 16'h0000;
      c_q      <= 16'h0000;
      d_q      <= 8'h00;
      byte_idx <= 4'd0;
      pack_num <= 8'h00;
    end else begin
      if (state == ST_IDLE && send_req) begin
        a_q      <= dataA;
        b_q      <= dataB;
        c_q      <= dataC;
        d_q      <= dataD;
        byte_idx <= 4'd0;
      end
      if (state == ST_NEXT) byte_idx <= byte_idx + 4'd1;
      if (state == ST_DONE) pack_num <= pack_num + 8'd1;
    end
  end

`ifdef UART_TX_CHECKSUM_EN
  logic [7:0] checksum;
  assign checksum = pack_num + a_q + b_q[15:8] + b_q[7:0] +
                    c_q[15:8] + c_q[7:0] + d_q;
`endif

  // Byte mux
  always_comb begin
    tx_byte = TAIL;
    case (sel_idx)
      4'd0: tx_byte = HDR0;
      4'd1: tx_byte = HDR1;
      4'd2: tx_byte = pack_num;
      4'd3: tx_byte = a_q;
      4'd4: tx_byte = b_q[15:8];
      4'd5: tx_byte = b_q[7:0];
      4'd6: tx_byte = c_q[15:8];
      4'd7: tx_byte = c_q[7:0];
      4'd8: tx_byte = d_q;
`ifdef UART_TX_CHECKSUM_EN
      4'd9: tx_byte = checksum;
`endif
      default: tx_byte = TAIL;
    endcase
  end

  uart_byte_tx #(
    .BAUD_CNT (BAUD_CNT)
  ) u_byte_tx (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (byte_start),
    .data      (tx_byte),
    .busy      (byte_busy),
    .done      (byte_done),
    .txd       (uart_txd)
  );

endmodule
